// File: rtl/lzc_pkg.sv
// Shared types and sizing helpers for the leading-zero normalizer.
package lzc_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        SHIFT   = 2'd2,
        OUT     = 2'd3
    } state_e;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_WORD  = 4;

    function automatic int cnt_w(input int total);
        return $clog2(total) + 1;
    endfunction

endpackage

// File: rtl/lzc_norm_shift_step.sv
// One stage of the log-step barrel shifter: shifts left by 2**step_i when enabled.
module lzc_norm_shift_step #(
    parameter int TOTAL = 32,
    parameter int SW    = 3
) (
    input  logic [TOTAL-1:0] din_i,
    input  logic [SW-1:0]    step_i,
    input  logic             en_i,
    output logic [TOTAL-1:0] dout_o
);

    always_comb begin
        dout_o = din_i;
        if (en_i) begin
            dout_o = din_i << (32'd1 << step_i);
        end
    end

endmodule

// File: rtl/lzc_normalize.sv
// Assembles a chunked value, waits for its leading-zero count, and left-normalizes it
// one power-of-two shift per cycle before presenting it on a valid/ready output.
module lzc_normalize
    import lzc_pkg::*;
#(
    parameter int  WIDTH = DEF_WIDTH,
    parameter int  WORD  = DEF_WORD,
    localparam int TOTAL = WIDTH * WORD,
    localparam int CNT_W = cnt_w(WIDTH * WORD),
    localparam int STEPS = $clog2(WIDTH * WORD)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data,
    input  logic             Ivalid,
    input  logic [CNT_W-1:0] zeros,
    input  logic             zvalid,
    output logic [TOTAL-1:0] norm,
    output logic [CNT_W-1:0] shamt,
    output logic             zero_flag,
    output logic             Ovalid,
    input  logic             Oready,
    output logic             drop_err
);

    localparam int SW  = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam int CCW = $clog2(WORD + 1);

    state_e           state_q, state_d;
    logic [TOTAL-1:0] val_q, val_d;
    logic [CCW-1:0]   cnt_q, cnt_d;
    logic             lat_q, lat_d;
    logic [CNT_W-1:0] zl_q, zl_d;
    logic [SW-1:0]    step_q, step_d;
    logic [TOTAL-1:0] norm_q, norm_d;
    logic [CNT_W-1:0] shamt_q, shamt_d;
    logic             zf_q, zf_d;
    logic             ovalid_q, ovalid_d;
    logic             drop_q, drop_d;
    logic [TOTAL-1:0] shifted;

    // A count above TOTAL is not produced by the lzc; clamp so it behaves as all-zero.
    function automatic logic [CNT_W-1:0] sat_zeros(input logic [CNT_W-1:0] z);
        return (z > CNT_W'(TOTAL)) ? CNT_W'(TOTAL) : z;
    endfunction

    lzc_norm_shift_step #(
        .TOTAL (TOTAL),
        .SW    (SW)
    ) u_step (
        .din_i  (val_q),
        .step_i (step_q),
        .en_i   (zl_q[step_q]),
        .dout_o (shifted)
    );

    always_comb begin
        state_d  = state_q;
        val_d    = val_q;
        cnt_d    = cnt_q;
        lat_d    = lat_q;
        zl_d     = zl_q;
        step_d   = step_q;
        norm_d   = norm_q;
        shamt_d  = shamt_q;
        zf_d     = zf_q;
        ovalid_d = ovalid_q;
        drop_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (Ivalid) begin
                    val_d   = {data, {(TOTAL-WIDTH){1'b0}}};
                    cnt_d   = CCW'(1);
                    state_d = COLLECT;
                end
            end
            COLLECT: begin
                if (Ivalid && cnt_q != CCW'(WORD)) begin
                    for (int k = 0; k < WORD; k++) begin
                        if (cnt_q == CCW'(k)) val_d[TOTAL-1-k*WIDTH -: WIDTH] = data;
                    end
                    cnt_d = cnt_q + 1'b1;
                end
                if (zvalid && !lat_q) begin
                    lat_d = 1'b1;
                    zl_d  = sat_zeros(zeros);
                end
                // Both the last chunk and the count may land on the same edge.
                if (cnt_d == CCW'(WORD) && lat_d) begin
                    if (zl_d == CNT_W'(TOTAL)) begin
                        state_d  = OUT;
                        norm_d   = '0;
                        shamt_d  = zl_d;
                        zf_d     = 1'b1;
                        ovalid_d = 1'b1;
                    end else begin
                        state_d = SHIFT;
                        step_d  = '0;
                    end
                end
            end
            SHIFT: begin
                drop_d = Ivalid;
                val_d  = shifted;
                step_d = step_q + 1'b1;
                if (step_q == SW'(STEPS - 1)) begin
                    state_d  = OUT;
                    norm_d   = shifted;
                    shamt_d  = zl_q;
                    zf_d     = 1'b0;
                    ovalid_d = 1'b1;
                end
            end
            OUT: begin
                drop_d = Ivalid;
                if (Oready) begin
                    state_d  = IDLE;
                    ovalid_d = 1'b0;
                    val_d    = '0;
                    cnt_d    = '0;
                    lat_d    = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            lat_q    <= 1'b0;
            norm_q   <= '0;
            shamt_q  <= '0;
            zf_q     <= 1'b0;
            ovalid_q <= 1'b0;
            drop_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            lat_q    <= lat_d;
            norm_q   <= norm_d;
            shamt_q  <= shamt_d;
            zf_q     <= zf_d;
            ovalid_q <= ovalid_d;
            drop_q   <= drop_d;
        end
    end

    always_ff @(posedge clk) begin
        val_q  <= val_d;
        zl_q   <= zl_d;
        step_q <= step_d;
    end

    assign norm      = norm_q;
    assign shamt     = shamt_q;
    assign zero_flag = zf_q;
    assign Ovalid    = ovalid_q;
    assign drop_err  = drop_q;

endmodule

// File: tb/tb_lzc_normalize.sv
// Directed plus randomized bench for lzc_normalize; the bench plays the role of the lzc.
module tb_lzc_normalize;

    localparam int TOTAL = 32;
    localparam int STEPS = 5;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  data;
    logic        Ivalid;
    logic [5:0]  zeros;
    logic        zvalid;
    logic [31:0] norm;
    logic [5:0]  shamt;
    logic        zero_flag;
    logic        Ovalid;
    logic        Oready;
    logic        drop_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lzc_normalize dut (
        .clk       (clk),
        .rst       (rst),
        .data      (data),
        .Ivalid    (Ivalid),
        .zeros     (zeros),
        .zvalid    (zvalid),
        .norm      (norm),
        .shamt     (shamt),
        .zero_flag (zero_flag),
        .Ovalid    (Ovalid),
        .Oready    (Oready),
        .drop_err  (drop_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int ref_lz(input logic [31:0] v);
        int n = 0;
        for (int b = 31; b >= 0 && !v[b]; b--) n++;
        return n;
    endfunction

    // Feed chunks MSB first on consecutive cycles; zvalid at cycle zv_at (and a bogus
    // second pulse with count 3 at zv2_at, or -1 for none). Requires zv2_at <= max(3, zv_at).
    task automatic run_txn(input logic [31:0] val, input int zv_at, input int zv2_at,
                           input int hold, input bit probe);
        int lz, t_edge, lat, exp_lat;
        logic [31:0] exp_n;
        lz      = ref_lz(val);
        exp_n   = val << lz;
        t_edge  = (zv_at > 3) ? zv_at : 3;
        exp_lat = (lz == TOTAL) ? 1 : STEPS;
        Oready  = 1'b0;
        for (int i = 0; i <= t_edge; i++) begin
            Ivalid = (i < 4);
            if (i < 4) data = val[31-8*i -: 8];
            else data = 8'h00;
            zvalid = (i == zv_at) || (i == zv2_at);
            zeros  = (i == zv_at) ? 6'(lz) : 6'd3;
            @(posedge clk); #1;
        end
        zvalid = 1'b0;
        data   = 8'h00;
        Ivalid = probe;
        lat    = 0;
        do begin
            @(posedge clk); #1;
            lat++;
            if (lat == 1) chk("drop_err_busy", drop_err, probe);
            Ivalid = 1'b0;
        end while (!Ovalid && lat < 30);
        chk("ovalid_rise", Ovalid, 1);
        chk("latency", lat, exp_lat);
        chk("norm", norm, exp_n);
        chk("shamt", shamt, lz);
        chk("zero_flag", zero_flag, (lz == TOTAL));
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            chk("hold_ovalid", Ovalid, 1);
            chk("hold_norm", norm, exp_n);
        end
        Oready = 1'b1;
        Ivalid = probe;
        @(posedge clk); #1;
        chk("ovalid_fall", Ovalid, 0);
        chk("drop_err_hs", drop_err, probe);
        Oready = 1'b0;
        Ivalid = 1'b0;
        @(posedge clk); #1;
        chk("drop_err_clear", drop_err, 0);
    endtask

    initial begin
        logic [31:0] rv;
        int zv, zv2;
        rst = 1'b1; data = 8'h00; Ivalid = 1'b0; zeros = 6'd0; zvalid = 1'b0; Oready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ovalid", Ovalid, 0);
        chk("rst_norm", norm, 0);
        chk("rst_shamt", shamt, 0);
        chk("rst_zero_flag", zero_flag, 0);
        chk("rst_drop_err", drop_err, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        run_txn(32'h000FA53C, 4, -1, 0, 1'b0);
        run_txn(32'h01223344, 1, -1, 0, 1'b0);
        run_txn(32'h00000000, 4, -1, 0, 1'b0);
        run_txn(32'h000FA53C, 4, -1, 3, 1'b1);

        // Reset while the shifter is at step 2.
        rv = 32'h000FA53C;
        for (int i = 0; i <= 4; i++) begin
            Ivalid = (i < 4);
            if (i < 4) data = rv[31-8*i -: 8];
            else data = 8'h00;
            zvalid = (i == 4);
            zeros  = 6'd12;
            @(posedge clk); #1;
        end
        Ivalid = 1'b0; zvalid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_ovalid", Ovalid, 0);
        chk("midrst_norm", norm, 0);
        chk("midrst_shamt", shamt, 0);
        repeat (8) @(posedge clk);
        #1;
        chk("midrst_idle", Ovalid, 0);
        run_txn(32'h80000000, 4, -1, 0, 1'b0);

        run_txn(32'h000FA53C, 1, 2, 0, 1'b0);

        for (int t = 0; t < 24; t++) begin
            rv  = $urandom;
            rv  = rv >> $urandom_range(0, 32);
            zv  = $urandom_range(1, 6);
            zv2 = (zv < 3 && $urandom_range(0, 1) == 1) ? zv + 1 : -1;
            run_txn(rv, zv, zv2, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
